mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between EX and WB. Accepts the EX->MEM bus and consumes data_sram_rdata
//  for loads issued by EX the previous cycle (synchronous RAM, 1-cycle read latency).
//  Performs byte/half selection and sign/zero extension, and forwards the write-back result to ID.
//  Passes CSR and exception info to WB. Holds returned load data stable while WB stalls.
// PARAMETERS
//  EX_MEM_BUS_W  173  width of ex_to_mem_bus (layout fixed below)
//  MEM_WB_BUS_W  199  width of mem_to_wb_bus (layout fixed below)
//  MEM_ID_BUS_W  39   width of mem_to_id_bus
// PORTS
//  clk              in   1    clock; all state updates on posedge
//  reset            in   1    synchronous, active-high reset
//  flush            in   1    exception/ertn flush from WB; kills the in-flight instruction
//  ex_to_mem_valid  in   1    EX holds a valid instruction for MEM
//  mem_allowin      out  1    MEM can accept from EX this cycle
//  ex_to_mem_bus    in   173  {pc32,res_from_mem,rf_we,rf_waddr5,alu_result32,rkd_value32,addr_lo2,op_b,op_h,op_u,
//                             csr_re,csr_we,csr_num14,csr_wmask32,ertn_flush,excep_en,ecode6,esubcode9} MSB->LSB
//  data_sram_rdata  in   32   sync-RAM read data; valid in first MEM cycle of a load
//  mem_to_ex_bus    out  1    mem_valid & (excep_en | ertn_flush): EX must suppress data_sram_en
//  mem_to_id_bus    out  39   {csr_re&valid, rf_we&valid, rf_waddr5, final_result32} for bypass/interlock
//  wb_allowin       in   1    WB can accept this cycle
//  mem_to_wb_valid  out  1    mem_valid & mem_ready_go
//  mem_to_wb_bus    out  199  {pc32,rf_we&valid,rf_waddr5,final_result32,rkd_value32,csr_re,csr_we,csr_num14,
//                             csr_wmask32,ertn_flush,excep_en,ecode6,esubcode9,vaddr32(=alu_result)}
// BEHAVIOUR
//  Handshake:
//  - mem_ready_go=1 (no internal stall source).
//  - mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
//  - Accept when ex_to_mem_valid & mem_allowin; bus fields are registered on that edge.
//  Valid register, priority reset > flush > allowin:
//  - reset or flush -> mem_valid=0.
//  - Else if mem_allowin -> mem_valid = ex_to_mem_valid.
//  - Payload registers are held when not accepting.
//  Outputs after reset:
//  - mem_valid=0; mem_to_wb_valid=0; mem_allowin=1; mem_to_ex_bus=0.
//  - Gated bits of mem_to_id_bus/mem_to_wb_bus (valid-qualified rf_we, csr_re) are 0; payload registers reset to 0.
//  Read-data hold (2-state FSM: LIVE, HELD; reset -> LIVE):
//  - LIVE: load data taken from data_sram_rdata.
//    If mem_valid & res_from_mem & ~(mem_to_wb_valid & wb_allowin): capture rdata into rdata_buf and go to HELD.
//  - HELD: load data taken from rdata_buf. Return to LIVE when the instruction leaves (wb_allowin), or on flush or reset.
//  - A new instruction accepted in the same edge as the departure always starts in LIVE.
//  Load extension, with a = addr_lo:
//  - op_b: byte = word[8a+7:8a].
//  - op_h: half = a[1] ? word[31:16] : word[15:0].
//  - Neither op_b nor op_h: whole word.
//  - op_u=1 zero-extends, else sign-extends (ignored for word).
//  final_result:
//  - res_from_mem ? extended load : alu_result.
//  - csr_re results are produced in WB; ID must stall on the csr_re flag.
//  Exceptions:
//  - If excep_en=1 the load data is don't-care and the FSM does not capture.
//  - ecode/esubcode/vaddr pass unchanged.
//  Flush with wb_allowin=0: the instruction is dropped next edge and no output stays valid.
// TESTING
//  1 reset=1 two cycles, then release -> mem_valid=0, mem_allowin=1, mem_to_ex_bus=0, mem_to_wb_valid=0.
//  2 ld.b addr_lo=3, rdata=0x80FF_0000, wb_allowin=1 -> final_result=0xFFFF_FF80; ld.bu same -> 0x0000_0080.
//  3 ld.h addr_lo=2, rdata=0x8001_1234, wb_allowin=0 for 3 cycles, rdata changes to 0xDEAD_BEEF on cycle 2
//    -> final_result stays 0xFFFF_8001 until handoff.
//  4 Instruction with excep_en=1 in MEM -> mem_to_ex_bus=1 same cycle; flush next edge -> mem_valid=0, FSM=LIVE.
//  5 Back-to-back ld.w then add (alu_result=0x10), wb_allowin=1 -> consecutive handoffs, add's result = 0x10 (not rdata).

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, extends sync-RAM load data, and
// holds returned load data in a buffer while WB back-pressures.
module mem_stage #(
   parameter int EX_MEM_BUS_W = 173,
   parameter int MEM_WB_BUS_W = 199,
   parameter int MEM_ID_BUS_W = 39
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    ex_to_mem_valid,
   output logic                    mem_allowin,
   input  logic [EX_MEM_BUS_W-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   output logic                    mem_to_ex_bus,
   output logic [MEM_ID_BUS_W-1:0] mem_to_id_bus,
   input  logic                    wb_allowin,
   output logic                    mem_to_wb_valid,
   output logic [MEM_WB_BUS_W-1:0] mem_to_wb_bus
);

   typedef struct packed {
      logic [31:0] pc;
      logic        res_from_mem;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] alu_result;
      logic [31:0] rkd_value;
      logic [1:0]  addr_lo;
      logic        op_b;
      logic        op_h;
      logic        op_u;
      logic        csr_re;
      logic        csr_we;
      logic [13:0] csr_num;
      logic [31:0] csr_wmask;
      logic        ertn_flush;
      logic        excep_en;
      logic [5:0]  ecode;
      logic [8:0]  esubcode;
   } ex_mem_t;

   typedef enum logic {LIVE, HELD} hold_t;

   ex_mem_t     in_bus;
   ex_mem_t     r;
   logic        mem_valid;
   logic        mem_ready_go;
   hold_t       state_q, state_d;
   logic [31:0] rdata_buf;
   logic        capture;
   logic [31:0] word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_ext;
   logic [31:0] final_result;

   assign in_bus          = ex_to_mem_bus;
   assign mem_ready_go    = 1'b1;
   assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
   assign mem_to_wb_valid = mem_valid & mem_ready_go;
   assign mem_to_ex_bus   = mem_valid & (r.excep_en | r.ertn_flush);

   always_ff @(posedge clk) begin
      if (reset)            mem_valid <= 1'b0;
      else if (flush)       mem_valid <= 1'b0;
      else if (mem_allowin) mem_valid <= ex_to_mem_valid;
   end

   always_ff @(posedge clk) begin
      if (reset)                                r <= '0;
      else if (ex_to_mem_valid && mem_allowin)  r <= in_bus;
   end

   // Capture only while the load is stuck in MEM; faulting instructions never capture.
   assign capture = mem_valid & r.res_from_mem & ~r.excep_en & ~(mem_to_wb_valid & wb_allowin);

   always_ff @(posedge clk) begin
      if (reset) state_q <= LIVE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LIVE: if (capture && !flush)       state_d = HELD;
         HELD: if (flush || wb_allowin)     state_d = LIVE;
         default:                           state_d = LIVE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                              rdata_buf <= '0;
      else if (state_q == LIVE && capture)    rdata_buf <= data_sram_rdata;
   end

   assign word = (state_q == HELD) ? rdata_buf : data_sram_rdata;

   always_comb begin
      ld_byte = word[7:0];
      case (r.addr_lo)
         2'd0:    ld_byte = word[7:0];
         2'd1:    ld_byte = word[15:8];
         2'd2:    ld_byte = word[23:16];
         default: ld_byte = word[31:24];
      endcase
   end

   assign ld_half = r.addr_lo[1] ? word[31:16] : word[15:0];

   always_comb begin
      load_ext = word;
      if (r.op_b)      load_ext = {{24{~r.op_u & ld_byte[7]}}, ld_byte};
      else if (r.op_h) load_ext = {{16{~r.op_u & ld_half[15]}}, ld_half};
   end

   assign final_result = r.res_from_mem ? load_ext : r.alu_result;

   assign mem_to_id_bus = {r.csr_re & mem_valid, r.rf_we & mem_valid, r.rf_waddr, final_result};

   assign mem_to_wb_bus = {r.pc, r.rf_we & mem_valid, r.rf_waddr, final_result, r.rkd_value,
                           r.csr_re, r.csr_we, r.csr_num, r.csr_wmask, r.ertn_flush, r.excep_en,
                           r.ecode, r.esubcode, r.alu_result};

endmodule
